// File: rtl/mem_access_unit.sv
// Memory stage: resolves branches, runs load/store over a valid/ack port, strobes writeback.
// 1-cycle result for non-memory ops; memory ops hold in_ready low until ack or timeout abort.
module mem_access_unit #(
  parameter int TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] alu_out,
  input  logic        zero,
  input  logic        overflow,
  input  logic [29:0] btarg,
  input  logic        branch,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [31:0] store_data,
  input  logic        reg_write,
  input  logic [4:0]  rw,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [29:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  input  logic        dmem_ack,
  input  logic [31:0] dmem_rdata,
  output logic        redirect,
  output logic [29:0] redirect_pc,
  output logic        wb_valid,
  output logic        wb_we,
  output logic [4:0]  wb_rw,
  output logic [31:0] wb_data,
  output logic        exc
);

  typedef enum logic {IDLE, ACCESS} state_t;

  localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

  state_t        state;
  logic [CW-1:0] cnt;
  logic          acc_load;
  logic          acc_rwe;
  logic          mem_op;

  assign mem_op   = mem_read | mem_write;
  assign in_ready = (state == IDLE) & ~rst;

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= '0;
      acc_load    <= 1'b0;
      acc_rwe     <= 1'b0;
      dmem_req    <= 1'b0;
      dmem_we     <= 1'b0;
      dmem_addr   <= '0;
      dmem_wdata  <= '0;
      redirect    <= 1'b0;
      redirect_pc <= '0;
      wb_valid    <= 1'b0;
      wb_we       <= 1'b0;
      wb_rw       <= '0;
      wb_data     <= '0;
      exc         <= 1'b0;
    end else begin
      redirect <= 1'b0;
      wb_valid <= 1'b0;
      wb_we    <= 1'b0;
      exc      <= 1'b0;
      case (state)
        IDLE: begin
          if (in_valid) begin
            wb_rw   <= rw;
            wb_data <= alu_out;
            // Branch decode takes precedence: its memory flags are don't-care.
            if (branch) begin
              wb_valid <= 1'b1;
              redirect <= zero;
              if (zero) redirect_pc <= btarg;
            end else if (overflow || (mem_op && alu_out[1:0] != 2'b00)) begin
              wb_valid <= 1'b1;
              exc      <= 1'b1;
            end else if (mem_op) begin
              state      <= ACCESS;
              cnt        <= '0;
              dmem_req   <= 1'b1;
              dmem_we    <= mem_write;
              dmem_addr  <= alu_out[31:2];
              dmem_wdata <= store_data;
              acc_load   <= ~mem_write;
              acc_rwe    <= reg_write;
            end else begin
              wb_valid <= 1'b1;
              wb_we    <= reg_write;
            end
          end
        end
        ACCESS: begin
          // Ack is tested first so an ack on the last allowed cycle wins over abort.
          if (dmem_ack) begin
            state    <= IDLE;
            dmem_req <= 1'b0;
            wb_valid <= 1'b1;
            wb_we    <= acc_load & acc_rwe;
            if (acc_load) wb_data <= dmem_rdata;
          end else if (cnt == LAST) begin
            state    <= IDLE;
            dmem_req <= 1'b0;
            wb_valid <= 1'b1;
            exc      <= 1'b1;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed and randomized checks of mem_access_unit against an instruction-level reference model.
module tb_mem_access_unit;
  localparam int TIMEOUT = 15;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] alu_out = '0;
  logic        zero = 1'b0;
  logic        overflow = 1'b0;
  logic [29:0] btarg = '0;
  logic        branch = 1'b0;
  logic        mem_read = 1'b0;
  logic        mem_write = 1'b0;
  logic [31:0] store_data = '0;
  logic        reg_write = 1'b0;
  logic [4:0]  rw = '0;
  logic        dmem_req;
  logic        dmem_we;
  logic [29:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic        dmem_ack = 1'b0;
  logic [31:0] dmem_rdata = '0;
  logic        redirect;
  logic [29:0] redirect_pc;
  logic        wb_valid;
  logic        wb_we;
  logic [4:0]  wb_rw;
  logic [31:0] wb_data;
  logic        exc;

  int total = 0;
  int bad = 0;

  mem_access_unit #(.TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .alu_out(alu_out), .zero(zero), .overflow(overflow), .btarg(btarg),
    .branch(branch), .mem_read(mem_read), .mem_write(mem_write),
    .store_data(store_data), .reg_write(reg_write), .rw(rw),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_wdata(dmem_wdata), .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
    .redirect(redirect), .redirect_pc(redirect_pc), .wb_valid(wb_valid),
    .wb_we(wb_we), .wb_rw(wb_rw), .wb_data(wb_data), .exc(exc)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, ".wb_valid"}, 32'(wb_valid), 32'd0);
    chk({tag, ".exc"}, 32'(exc), 32'd0);
    chk({tag, ".redirect"}, 32'(redirect), 32'd0);
  endtask

  // Issue one instruction and check its whole lifetime. ack_at = request cycle
  // in which memory acks (1 = first), 0 = never.
  task automatic do_op(input string tag, input logic br, input logic z, input logic ov,
                       input logic rd, input logic wr, input logic rwe,
                       input logic [31:0] alu, input logic [31:0] sd,
                       input logic [29:0] bt, input logic [4:0] rd_reg, input int ack_at);
    logic is_mem, fault, acked;
    logic [31:0] rdata;
    @(negedge clk);
    chk({tag, ".ready"}, 32'(in_ready), 32'd1);
    chk_quiet({tag, ".pre"});
    in_valid = 1'b1; branch = br; zero = z; overflow = ov; mem_read = rd; mem_write = wr;
    reg_write = rwe; alu_out = alu; store_data = sd; btarg = bt; rw = rd_reg;
    @(negedge clk);
    in_valid = 1'b0;
    is_mem = !br && !ov && (rd || wr) && (alu[1:0] == 2'b00);
    fault  = !br && (ov || ((rd || wr) && alu[1:0] != 2'b00));
    if (!is_mem) begin
      chk({tag, ".wb_valid"}, 32'(wb_valid), 32'd1);
      chk({tag, ".exc"}, 32'(exc), 32'(fault));
      chk({tag, ".redirect"}, 32'(redirect), 32'(br && z));
      if (br && z) chk({tag, ".redirect_pc"}, 32'(redirect_pc), 32'(bt));
      chk({tag, ".wb_we"}, 32'(wb_we), 32'(!br && !fault && rwe));
      if (!br && !fault && rwe) begin
        chk({tag, ".wb_rw"}, 32'(wb_rw), 32'(rd_reg));
        chk({tag, ".wb_data"}, wb_data, alu);
      end
      chk({tag, ".no_req"}, 32'(dmem_req), 32'd0);
    end else begin
      acked = 1'b0;
      rdata = $urandom;
      for (int k = 1; k <= TIMEOUT && !acked; k++) begin
        chk({tag, ".req"}, 32'(dmem_req), 32'd1);
        chk({tag, ".we"}, 32'(dmem_we), 32'(wr));
        chk({tag, ".addr"}, 32'(dmem_addr), 32'(alu[31:2]));
        chk({tag, ".wdata"}, dmem_wdata, sd);
        chk({tag, ".busy"}, 32'(in_ready), 32'd0);
        chk({tag, ".no_wb"}, 32'(wb_valid), 32'd0);
        if (k == ack_at) begin
          dmem_ack = 1'b1;
          dmem_rdata = rdata;
          acked = 1'b1;
        end
        @(negedge clk);
        dmem_ack = 1'b0;
        dmem_rdata = $urandom;
      end
      chk({tag, ".req_drop"}, 32'(dmem_req), 32'd0);
      chk({tag, ".wb_valid"}, 32'(wb_valid), 32'd1);
      chk({tag, ".exc"}, 32'(exc), 32'(!acked));
      chk({tag, ".wb_we"}, 32'(wb_we), 32'(acked && !wr && rwe));
      chk({tag, ".ready_after"}, 32'(in_ready), 32'd1);
      if (acked) chk({tag, ".wb_rw"}, 32'(wb_rw), 32'(rd_reg));
      if (acked && !wr) chk({tag, ".wb_data"}, wb_data, rdata);
    end
  endtask

  initial begin
    // Reset state
    repeat (2) @(negedge clk);
    chk("rst.ready", 32'(in_ready), 32'd0);
    chk("rst.req", 32'(dmem_req), 32'd0);
    chk("rst.wb", 32'(wb_valid), 32'd0);
    chk("rst.wb_data", wb_data, 32'd0);
    chk("rst.exc", 32'(exc), 32'd0);
    rst = 1'b0;

    // Directed cases
    do_op("alu", 0, 0, 0, 0, 0, 1, 32'h10, 32'h0, 30'h0, 5'd5, 0);
    do_op("branch", 1, 1, 0, 1, 0, 1, 32'h0, 32'h0, 30'h100, 5'd3, 0);
    do_op("branch_nt", 1, 0, 0, 0, 0, 0, 32'h4, 32'h0, 30'h200, 5'd3, 0);
    do_op("load", 0, 0, 0, 1, 0, 1, 32'h40, 32'h0, 30'h0, 5'd7, 3);
    do_op("load0w", 0, 0, 0, 1, 0, 1, 32'h1234, 32'h0, 30'h0, 5'd9, 1);
    do_op("misal", 0, 0, 0, 0, 1, 0, 32'h2, 32'h55, 30'h0, 5'd0, 0);
    do_op("ovf", 0, 0, 1, 0, 0, 1, 32'h7fff_ffff, 32'h0, 30'h0, 5'd4, 0);
    do_op("st_to", 0, 0, 0, 0, 1, 0, 32'h80, 32'hA5A5_5A5A, 30'h0, 5'd0, 0);
    do_op("st_ack15", 0, 0, 0, 0, 1, 0, 32'h84, 32'h1111_2222, 30'h0, 5'd0, TIMEOUT);

    // Stray ack while idle must be ignored
    @(negedge clk);
    dmem_ack = 1'b1;
    @(negedge clk);
    dmem_ack = 1'b0;
    chk_quiet("stray_ack");
    chk("stray_ack.ready", 32'(in_ready), 32'd1);

    // Back-to-back ALU ops: one result per cycle
    @(negedge clk);
    in_valid = 1'b1; branch = 0; overflow = 0; mem_read = 0; mem_write = 0;
    reg_write = 1; rw = 5'd1; alu_out = 32'hAAAA_0001;
    @(negedge clk);
    chk("b2b.ready", 32'(in_ready), 32'd1);
    chk("b2b.a_data", wb_data, 32'hAAAA_0001);
    rw = 5'd2; alu_out = 32'hBBBB_0002;
    @(negedge clk);
    in_valid = 1'b0;
    chk("b2b.b_valid", 32'(wb_valid), 32'd1);
    chk("b2b.b_rw", 32'(wb_rw), 32'd2);
    chk("b2b.b_data", wb_data, 32'hBBBB_0002);

    // Reset in the middle of an access
    @(negedge clk);
    in_valid = 1'b1; mem_read = 1'b1; reg_write = 1'b1; alu_out = 32'h100; rw = 5'd6;
    @(negedge clk);
    in_valid = 1'b0; mem_read = 1'b0;
    repeat (2) @(negedge clk);
    chk("mid.req", 32'(dmem_req), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    chk("mid_rst.req", 32'(dmem_req), 32'd0);
    chk("mid_rst.addr", 32'(dmem_addr), 32'd0);
    chk("mid_rst.ready", 32'(in_ready), 32'd0);
    chk_quiet("mid_rst");
    rst = 1'b0;
    @(negedge clk);
    chk_quiet("post_rst");
    chk("post_rst.req", 32'(dmem_req), 32'd0);
    do_op("post_rst_alu", 0, 0, 0, 0, 0, 1, 32'h99, 32'h0, 30'h0, 5'd8, 0);

    // Randomized instruction mix
    for (int i = 0; i < 60; i++) begin
      int kind;
      logic [31:0] a;
      kind = $urandom_range(0, 5);
      a = $urandom;
      if ($urandom_range(0, 3) != 0) a[1:0] = 2'b00;
      do_op($sformatf("rnd%0d", i),
            kind == 0, 1'($urandom), kind == 1 || $urandom_range(0, 9) == 0,
            kind == 2, kind == 3, 1'($urandom), a, $urandom, 30'($urandom),
            5'($urandom), int'($urandom_range(0, TIMEOUT)));
    end

    @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_access_unit.md
# mem_access_unit

Memory-stage block of the pipelined CPU, sitting directly downstream of the execute stage. It accepts one execute-stage result per handshake, resolves taken branches into a PC redirect, and performs load/store accesses over a valid/ack data-memory port. It also suppresses writeback on arithmetic overflow, misalignment or bus timeout, and presents a single-cycle writeback strobe to the register file.

## Interface
- TIMEOUT, 15, max cycles dmem_req may stay high without dmem_ack before abort (≥2)
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  reset, synchronous, active-high
- in_valid  in  1  execute stage presents a result
- in_ready  out  1  block can accept; transfer on in_valid & in_ready at a rising edge
- alu_out  in  32  ALU result / byte address for memory ops
- zero  in  1  ALU zero flag
- overflow  in  1  ALU overflow flag
- btarg  in  30  branch target word address
- branch  in  1  instruction is a conditional branch (taken when zero=1)
- mem_read  in  1  load word
- mem_write  in  1  store word
- store_data  in  32  busB value to store
- reg_write  in  1  instruction writes a register
- rw  in  5  destination register
- dmem_req  out  1  data-memory request
- dmem_we  out  1  request is a write
- dmem_addr  out  30  word address (alu_out[31:2])
- dmem_wdata  out  32  store data
- dmem_ack  in  1  memory completes request this cycle
- dmem_rdata  in  32  load data, valid with dmem_ack
- redirect  out  1  one-cycle taken-branch pulse
- redirect_pc  out  30  target word address, valid with redirect
- wb_valid  out  1  one-cycle writeback strobe
- wb_we  out  1  register write enable, valid with wb_valid
- wb_rw  out  5  destination register
- wb_data  out  32  alu_out, or load data for loads
- exc  out  1  one-cycle exception pulse (overflow, misaligned, timeout)

## Operation
- States: IDLE, ACCESS. in_ready = (state==IDLE) & ~rst.
- IDLE, on accept:
  - branch=1: mem_read and mem_write ignored. If zero=1, redirect=1 and redirect_pc=btarg next cycle. wb_valid=1 with wb_we=0.
  - overflow=1: exc=1 and wb_valid=1 with wb_we=0 next cycle, no memory access.
  - mem op (mem_read|mem_write) with alu_out[1:0]≠0: exc=1 and wb_valid=1 with wb_we=0 next cycle, no request.
  - aligned mem op: go to ACCESS. Drive dmem_req=1, dmem_we=mem_write, dmem_addr, dmem_wdata from the captured values.
  - otherwise: wb_valid=1, wb_we=reg_write, wb_data=alu_out, wb_rw=rw next cycle.
- ACCESS: dmem_req and all dmem_* outputs held stable until ack or abort. The timeout counter increments each ACCESS cycle.
  - dmem_ack=1: return to IDLE. Next cycle wb_valid=1, wb_rw=rw. Load: wb_we=reg_write, wb_data=dmem_rdata (captured). Store: wb_we=0.
  - No ack by TIMEOUT cycles: dmem_req drops, return to IDLE, exc=1 and wb_valid=1 with wb_we=0 next cycle.
  - An ack on the final (TIMEOUT-th) cycle wins over abort.
- dmem_ack while dmem_req=0 is ignored.
- Reset: state IDLE, counter 0. All outputs 0: in_ready, dmem_*, redirect, redirect_pc, wb_*, exc. Reset during ACCESS drops dmem_req at that edge and produces no writeback.

## Timing
- Non-memory, branch, overflow and misaligned: accept at edge N; result pulses visible for exactly cycle N+1.
- in_ready stays 1 in IDLE, so back-to-back accepts give one result per cycle.
- Memory op: accept at edge N; dmem_req=1 from N+1. Ack sampled at edge M; wb_valid during M+1; in_ready=1 from M+1.
- Zero-wait memory (ack in first request cycle) gives 2-cycle load latency.
- Timeout: dmem_req high for exactly TIMEOUT cycles, then exc in the following cycle.
- Pulses (redirect, wb_valid, exc) never last more than one cycle per accepted instruction.

## Test plan
- ALU op alu_out=0x0000_0010, reg_write=1, rw=5 -> wb_valid one cycle later: wb_we=1, wb_rw=5, wb_data=0x10; no dmem_req.
- Branch zero=1, btarg=0x0000_0100 with mem_read=1 -> redirect=1, redirect_pc=0x100 for one cycle; wb_we=0; no dmem_req.
- Load alu_out=0x0000_0040, ack after 3 cycles with rdata=0xDEAD_BEEF -> dmem_addr=0x10 held 3 cycles, in_ready=0 meanwhile; then wb_data=0xDEADBEEF, wb_we=1.
- Store alu_out=0x2, store_data=0x55 -> exc=1, wb_we=0, dmem_req never asserted. Overflow=1 on ALU op -> exc=1, wb_we=0.
- Store with ack never returned, TIMEOUT=15 -> dmem_req high exactly 15 cycles, then exc=1 for one cycle, then in_ready=1. Repeat with ack on cycle 15 -> no exc, wb_valid with wb_we=0.
- rst pulsed during ACCESS -> dmem_req=0 and all outputs 0 after that edge; no wb_valid; next accept after reset works normally.
